// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the alu_sched scheduler and its arbiter.
package alu_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned NUM_REQ_DEF    = 2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PAR  = 2'b10;
    localparam logic [1:0] OP_COMP = 2'b11;

    // Number of WAIT cycles allowed before a missing done is declared a timeout
    localparam int unsigned TIMEOUT_LIM = 2;
    localparam int unsigned TIMEOUT_CW  = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_OPA  = 3'd1;
    localparam state_t ST_OPB  = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_RESP = 3'd4;

endpackage

// File: rtl/alu_sched_arb.sv
// alu_rr_arb: 2-way round-robin arbiter; last pointer resets to 1 so requester 0 wins the first tie.
module alu_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic r_last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            r_last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler driving the serial-operand ALU protocol.
// Optional feature: define ALU_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT_LIM cycles with rsp_err.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [1:0]            req_op0,
    input  logic [1:0]            req_op1,
    input  logic [DATA_WIDTH-1:0] req_a0,
    input  logic [DATA_WIDTH-1:0] req_a1,
    input  logic [DATA_WIDTH-1:0] req_b0,
    input  logic [DATA_WIDTH-1:0] req_b1,
    output logic [NUM_REQ-1:0]    req_gnt,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic                  overflow,
    input  logic [DATA_WIDTH-1:0] result,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_err
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_gnt;
    logic [1:0]            w_gnt_nxt;
    logic [1:0]            w_arb_gnt;
    logic                  w_arb_en;
    logic                  r_id;
    logic                  w_id_nxt;
    logic [1:0]            r_op;
    logic [1:0]            w_op_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] w_a_nxt;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic                  r_opcode_valid;
    logic                  w_opcode_valid_nxt;
    logic                  r_opcode;
    logic                  w_opcode_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid_nxt;
    logic                  r_rsp_id;
    logic                  w_rsp_id_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic [DATA_WIDTH-1:0] w_rsp_result_nxt;
    logic                  r_rsp_overflow;
    logic                  w_rsp_overflow_nxt;
    logic                  r_rsp_err;
    logic                  w_rsp_err_nxt;
    logic                  w_timeout;

    alu_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (2'(req_valid)),
        .en      (w_arb_en),
        .gnt     (w_arb_gnt)
    );

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [TIMEOUT_CW-1:0] r_wait_cnt;

    // Counts consecutive WAIT cycles; cleared in every other state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TIMEOUT_CW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_wait_cnt == TIMEOUT_CW'(TIMEOUT_LIM - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic; bus outputs follow the state being entered
    always_comb begin
        w_state_nxt        = r_state;
        w_gnt_nxt          = 2'b00;
        w_id_nxt           = r_id;
        w_op_nxt           = r_op;
        w_a_nxt            = r_a;
        w_b_nxt            = r_b;
        w_arb_en           = 1'b0;
        w_opcode_valid_nxt = 1'b0;
        w_opcode_nxt       = 1'b0;
        w_data_nxt         = '0;
        w_rsp_valid_nxt    = 1'b0;
        w_rsp_id_nxt       = 1'b0;
        w_rsp_result_nxt   = '0;
        w_rsp_overflow_nxt = 1'b0;
        w_rsp_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A granted request leaves IDLE one cycle after its grant pulse
                if (r_gnt != 2'b00) begin
                    w_state_nxt = ST_OPA;
                end else begin
                    w_arb_en = |req_valid;
                end
            end
            ST_OPA:  w_state_nxt = ST_OPB;
            ST_OPB:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (done) begin
                    w_state_nxt        = ST_RESP;
                    w_rsp_result_nxt   = result;
                    w_rsp_overflow_nxt = overflow;
                end else if (w_timeout) begin
                    w_state_nxt   = ST_RESP;
                    w_rsp_err_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_arb_en    = |req_valid;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_arb_en) begin
            w_gnt_nxt = w_arb_gnt;
            w_id_nxt  = w_arb_gnt[1];
            w_op_nxt  = w_arb_gnt[1] ? req_op1 : req_op0;
            w_a_nxt   = w_arb_gnt[1] ? req_a1  : req_a0;
            w_b_nxt   = w_arb_gnt[1] ? req_b1  : req_b0;
        end

        if (w_state_nxt == ST_RESP) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_id_nxt    = r_id;
        end

        case (w_state_nxt)
            ST_OPA: begin
                w_opcode_valid_nxt = 1'b1;
                w_opcode_nxt       = r_op[0];
                w_data_nxt         = r_a;
            end
            ST_OPB: begin
                w_opcode_valid_nxt = 1'b1;
                w_opcode_nxt       = r_op[1];
                w_data_nxt         = r_b;
            end
            ST_WAIT: w_opcode_valid_nxt = 1'b1;
            default: w_opcode_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_gnt          <= 2'b00;
            r_id           <= 1'b0;
            r_op           <= 2'b00;
            r_a            <= '0;
            r_b            <= '0;
            r_opcode_valid <= 1'b0;
            r_opcode       <= 1'b0;
            r_data         <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gnt          <= w_gnt_nxt;
            r_id           <= w_id_nxt;
            r_op           <= w_op_nxt;
            r_a            <= w_a_nxt;
            r_b            <= w_b_nxt;
            r_opcode_valid <= w_opcode_valid_nxt;
            r_opcode       <= w_opcode_nxt;
            r_data         <= w_data_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_id       <= w_rsp_id_nxt;
            r_rsp_result   <= w_rsp_result_nxt;
            r_rsp_overflow <= w_rsp_overflow_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
        end
    end

    assign req_gnt      = NUM_REQ'(r_gnt);
    assign opcode_valid = r_opcode_valid;
    assign opcode       = r_opcode;
    assign data         = r_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched; the ALU is a stub driven by the bench.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int          NEVER = int'(TIMEOUT_LIM);

    logic          clk;
    logic          reset_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_op0;
    logic [1:0]    req_op1;
    logic [DW-1:0] req_a0;
    logic [DW-1:0] req_a1;
    logic [DW-1:0] req_b0;
    logic [DW-1:0] req_b1;
    logic [1:0]    req_gnt;
    logic          opcode_valid;
    logic          opcode;
    logic [DW-1:0] data;
    logic          done;
    logic          overflow;
    logic [DW-1:0] result;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_err;

    int n_checks;
    int n_errors;

    alu_sched #(.DATA_WIDTH(DW), .NUM_REQ(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .req_gnt      (req_gnt),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .done         (done),
        .overflow     (overflow),
        .result       (result),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (id == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[id] = 1'b1;
    endtask

    // Follows one operation from its grant cycle T to the RESP cycle; dly: 0 done at T+3, 1 at T+4, NEVER none
    task automatic serve(input int id, input logic [1:0] op, input logic [DW-1:0] ea,
                         input logic [DW-1:0] eb, input int dly, input logic [DW-1:0] res,
                         input logic ovf, input bit drop);
        logic [1:0] exp_gnt;
        exp_gnt = (id == 0) ? 2'b01 : 2'b10;
        tick();
        chk("gnt", 32'(req_gnt), 32'(exp_gnt));
        chk("gnt_ov", 32'(opcode_valid), 32'd0);
        if (drop) req_valid[id] = 1'b0;
        tick();
        chk("opa_ov", 32'(opcode_valid), 32'd1);
        chk("opa_op", 32'(opcode), 32'(op[0]));
        chk("opa_data", 32'(data), 32'(ea));
        chk("opa_gnt", 32'(req_gnt), 32'd0);
        tick();
        chk("opb_ov", 32'(opcode_valid), 32'd1);
        chk("opb_op", 32'(opcode), 32'(op[1]));
        chk("opb_data", 32'(data), 32'(eb));
        tick();
        chk("wait_ov", 32'(opcode_valid), 32'd1);
        chk("wait_data", 32'({opcode, data}), 32'd0);
        if (dly == NEVER) begin
            result = 8'hEE; overflow = 1'b1;
        end else begin
            result = res; overflow = ovf;
        end
        if (dly == 0) done = 1'b1;
        if (dly > 0) begin
            tick();
            chk("wait2_ov", 32'(opcode_valid), 32'd1);
            chk("wait2_rsp", 32'(rsp_valid), 32'd0);
            if (dly == 1) done = 1'b1;
        end
        tick();
        done = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_result", 32'(rsp_result), 32'((dly == NEVER) ? 8'h00 : res));
        chk("rsp_ovf", 32'(rsp_overflow), 32'((dly == NEVER) ? 1'b0 : ovf));
        chk("rsp_err", 32'(rsp_err), 32'(dly == NEVER));
        chk("rsp_bus", 32'({opcode_valid, opcode, data}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0; req_valid = 2'b00;
        req_op0 = 2'b00; req_op1 = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        done = 1'b0; overflow = 1'b0; result = '0;
        n_checks = 0; n_errors = 0;

        // Both requesters valid out of reset
        set_req(0, OP_SUB, 8'h05, 8'h03);
        set_req(1, OP_COMP, 8'hAA, 8'h55);
        tick();
        tick();
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_bus", 32'({opcode_valid, opcode, data}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err}), 32'd0);
        reset_n = 1'b1;

        serve(0, OP_SUB, 8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b1);
        serve(1, OP_COMP, 8'hAA, 8'h55, 0, 8'h00, 1'b0, 1'b1);

        // Fairness: req1 held, req0 re-asserted after its grant
        set_req(0, OP_ADD, 8'h03, 8'h04);
        set_req(1, OP_PAR, 8'h0F, 8'h01);
        serve(0, OP_ADD, 8'h03, 8'h04, 0, 8'h07, 1'b0, 1'b1);
        set_req(0, OP_SUB, 8'h09, 8'h02);
        serve(1, OP_PAR, 8'h0F, 8'h01, 0, 8'h00, 1'b0, 1'b0);
        serve(0, OP_SUB, 8'h09, 8'h02, 0, 8'h07, 1'b0, 1'b1);
        serve(1, OP_PAR, 8'h0F, 8'h01, 0, 8'h00, 1'b0, 1'b1);

        tick();
        chk("idle_rsp", 32'(rsp_valid), 32'd0);

        // Single request with overflowing ADD
        set_req(0, OP_ADD, 8'hF0, 8'h20);
        serve(0, OP_ADD, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b1);

        // Slow done at T+4
        set_req(1, OP_SUB, 8'h40, 8'h41);
        serve(1, OP_SUB, 8'h40, 8'h41, 1, 8'hFF, 1'b1, 1'b1);

        // Spurious done outside WAIT
        done = 1'b1; result = 8'h5A; overflow = 1'b1;
        tick();
        chk("spur_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("spur_rsp2", 32'(rsp_valid), 32'd0);
        chk("spur_bus", 32'(opcode_valid), 32'd0);
        done = 1'b0;

`ifdef ALU_SCHED_TIMEOUT_EN
        set_req(0, OP_PAR, 8'h3C, 8'h00);
        serve(0, OP_PAR, 8'h3C, 8'h00, NEVER, 8'h00, 1'b0, 1'b1);
        set_req(1, OP_ADD, 8'h01, 8'h02);
        serve(1, OP_ADD, 8'h01, 8'h02, 0, 8'h03, 1'b0, 1'b1);
`endif

        // Reset during OPB aborts the operation; pending req1 is served afterwards
        set_req(0, OP_ADD, 8'h11, 8'h22);
        tick();
        chk("ab_gnt", 32'(req_gnt), 32'd1);
        req_valid[0] = 1'b0;
        tick();
        chk("ab_opa", 32'(opcode_valid), 32'd1);
        tick();
        chk("ab_opb", 32'(data), 32'h22);
        set_req(1, OP_COMP, 8'h33, 8'h44);
        reset_n = 1'b0;
        #1;
        chk("ab_bus", 32'({opcode_valid, opcode, data}), 32'd0);
        chk("ab_out", 32'({req_gnt, rsp_valid, rsp_result, rsp_err}), 32'd0);
        tick();
        chk("ab_rsp", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        serve(1, OP_COMP, 8'h33, 8'h44, 0, 8'h01, 1'b0, 1'b1);

        tick();
        chk("end_rsp", 32'(rsp_valid), 32'd0);
        chk("end_gnt", 32'(req_gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
